// File: rtl/vpu_pkg.sv
// Shared types and constants for the VPU instruction fetch path.
package vpu_pkg;

  localparam int INSTR_W = 32;
  localparam logic [6:0] VPU_OPCODE = 7'b1111111;
  localparam logic [INSTR_W-1:0] END_INSTR = 32'h0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/vpu_fetch_fifo.sv
// Synchronous fetch buffer holding {pc, instr} entries; flush outranks push.
module vpu_fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != FULL_CNT) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/vpu_fetch_sequencer.sv
// VPU fetch sequencer: walks the instruction ROM and buffers {pc, instr} for decode.
// Optional perf counters (perf_fetched, perf_stall) are built when VPU_FETCH_PERF_EN is defined.
module vpu_fetch_sequencer
  import vpu_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                IMEM_BYTES = 100,
  parameter logic [ADDR_W-1:0] PC_RESET   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_pc,
  input  logic [31:0]       imem_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              busy,
  output logic              halted,
  output logic              fault,
  output logic [1:0]        dbg_state
`ifdef VPU_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]  IMEM_LIMIT = (ADDR_W+1)'(IMEM_BYTES);

  fetch_state_e            state_q, state_d;
  logic [ADDR_W-1:0]       pc_q, pc_d;
  logic                    fault_q, fault_d;
  logic                    push, flush, pop, has_room, out_of_range, redirect_take;
  logic [CNT_W-1:0]        fifo_count;
  logic [ADDR_W+INSTR_W-1:0] head;

  // Decode handshake: the head transfers on every edge where instr_valid && instr_ready;
  // while instr_valid && !instr_ready the head word and its PC are held unchanged.
  assign instr_valid   = (fifo_count != '0);
  assign pop           = instr_valid && instr_ready;
  assign has_room      = (fifo_count != FULL_CNT) || pop;
  assign out_of_range  = ({1'b0, pc_q} + (ADDR_W+1)'(4)) > IMEM_LIMIT;
  assign redirect_take = redirect_valid && (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect_take) begin
      flush = 1'b1;
      if (redirect_pc[1:0] != 2'b00) begin
        fault_d = 1'b1;
        state_d = HALT;
      end else begin
        pc_d    = redirect_pc;
        state_d = FETCH;
      end
    end else begin
      case (state_q)
        IDLE, HALT: begin
          if (start) begin
            pc_d    = PC_RESET;
            fault_d = 1'b0;
            state_d = FETCH;
          end
        end
        FETCH: begin
          if (out_of_range) begin
            fault_d = 1'b1;
            state_d = DRAIN;
          end else if (imem_instr == END_INSTR) begin
            state_d = DRAIN;
          end else if (has_room) begin
            push = 1'b1;
            pc_d = pc_q + ADDR_W'(4);
          end
        end
        DRAIN: begin
          if (fifo_count == '0) state_d = HALT;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= PC_RESET;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  vpu_fetch_fifo #(
    .WIDTH (ADDR_W + INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({pc_q, imem_instr}),
    .rdata (head),
    .count (fifo_count)
  );

  assign {instr_pc, instr} = instr_valid ? head : '0;
  assign imem_pc   = pc_q;
  assign busy      = (state_q == FETCH) || (state_q == DRAIN);
  assign halted    = (state_q == HALT);
  assign fault     = fault_q;
  assign dbg_state = state_q;

`ifdef VPU_FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;
  logic        start_acc, stall;

  assign start_acc = start && ((state_q == IDLE) || ((state_q == HALT) && !redirect_valid));
  assign stall     = (state_q == FETCH) && !redirect_valid && !out_of_range &&
                     (imem_instr != END_INSTR) && !has_room;

  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (push && (perf_fetched_q != '1)) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (stall && (perf_stall_q != '1))  perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_vpu_fetch_sequencer.sv
// Self-checking bench for vpu_fetch_sequencer: directed scenarios plus randomized programs
// scored against a program-walk reference model.
module tb_vpu_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, redirect_valid, instr_ready;
  logic [31:0] redirect_pc;

  logic [31:0] imem_pc, imem_instr, instr, instr_pc;
  logic        instr_valid, busy, halted, fault;
  logic [1:0]  dbg_state;

  logic [31:0] s_imem_pc, s_imem_instr, s_instr, s_instr_pc;
  logic        s_instr_valid, s_busy, s_halted, s_fault;
  logic [1:0]  s_dbg_state;

`ifdef VPU_FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall, s_perf_fetched, s_perf_stall;
`endif

  logic [31:0] rom   [0:31];
  logic [31:0] rom20 [0:7];
  assign imem_instr   = rom[imem_pc[6:2]];
  assign s_imem_instr = rom20[s_imem_pc[4:2]];

  logic [63:0] exp_q[$];
  bit          exp_fault;
  int          checks = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  vpu_fetch_sequencer #(.IMEM_BYTES(100)) dut (
    .clk(clk), .reset(reset), .start(start), .imem_pc(imem_pc), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .busy(busy),
    .halted(halted), .fault(fault), .dbg_state(dbg_state)
`ifdef VPU_FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  vpu_fetch_sequencer #(.IMEM_BYTES(20)) dut20 (
    .clk(clk), .reset(reset), .start(start), .imem_pc(s_imem_pc), .imem_instr(s_imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(s_instr_valid),
    .instr_ready(instr_ready), .instr(s_instr), .instr_pc(s_instr_pc), .busy(s_busy),
    .halted(s_halted), .fault(s_fault), .dbg_state(s_dbg_state)
`ifdef VPU_FETCH_PERF_EN
    , .perf_fetched(s_perf_fetched), .perf_stall(s_perf_stall)
`endif
  );

  // Reference: walk the program word by word until an end marker or the range limit.
  task automatic model_program(input logic [31:0] pc0);
    logic [31:0] pc;
    pc = pc0;
    exp_q.delete();
    exp_fault = 1'b0;
    while (1) begin
      if (pc + 32'd4 > 32'd100) begin exp_fault = 1'b1; break; end
      if (rom[pc[6:2]] == 32'h0) break;
      exp_q.push_back({pc, rom[pc[6:2]]});
      pc = pc + 32'd4;
    end
  endtask

  task automatic load_short_rom();
    for (int i = 0; i < 32; i++) rom[i] = (i < 5) ? (32'hC0DE_0000 + 32'(i * 17 + 1)) : 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs until halted, popping with the chosen ready pattern and scoring every transfer.
  task automatic run_stream(input bit rand_ready, input int limit, input string name);
    int n;
    bit stalled;
    logic [63:0] held, e;
    n = 0; stalled = 1'b0; held = '0;
    while (n < limit) begin
      instr_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (halted) break;
      if (stalled && instr_valid) begin
        checks++;
        if ({instr_pc, instr} !== held) $display("FAIL %s_hold: got %h want %h", name, {instr_pc, instr}, held);
        else passed++;
      end
      if (instr_valid && instr_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL %s_extra: got pc %h want none", name, instr_pc);
        else begin
          e = exp_q.pop_front();
          if ({instr_pc, instr} !== e) $display("FAIL %s_data: got %h want %h", name, {instr_pc, instr}, e);
          else passed++;
        end
        stalled = 1'b0;
      end else if (instr_valid) begin
        stalled = 1'b1; held = {instr_pc, instr};
      end else stalled = 1'b0;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= limit) $display("FAIL %s_timeout: got %0d cycles want halt", name, n);
    else passed++;
    checks++;
    if (exp_q.size() != 0) $display("FAIL %s_missing: got %0d left want 0", name, exp_q.size());
    else passed++;
    checks++;
    if (fault !== exp_fault) $display("FAIL %s_fault: got %0b want %0b", name, fault, exp_fault);
    else passed++;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({instr_valid, busy, halted, fault} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {instr_valid, busy, halted, fault});
    else passed++;
    checks++;
    if (imem_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", imem_pc);
    else passed++;
    checks++;
    if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state);
    else passed++;
  endtask

  task automatic test_single_stream();
    logic [63:0] e;
    int n;
    do_reset();
    load_short_rom();
    model_program(32'h0);
    instr_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    checks++;
    if (instr_valid !== 1'b0 || busy !== 1'b1) $display("FAIL stream_t1: got valid %0b busy %0b want 0 1", instr_valid, busy);
    else passed++;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      e = exp_q.pop_front();
      checks++;
      if (instr_valid !== 1'b1 || {instr_pc, instr} !== e) $display("FAIL stream_seq%0d: got %0b %h want 1 %h", k, instr_valid, {instr_pc, instr}, e);
      else passed++;
      @(negedge clk);
    end
    n = 0; #1;
    while (!halted && n < 10) begin @(negedge clk); #1; n++; end
    checks++;
    if ({halted, fault, instr_valid, busy} !== 4'b1000) $display("FAIL stream_end: got %b want 1000", {halted, fault, instr_valid, busy});
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [63:0] e;
    do_reset();
    load_short_rom();
    model_program(32'h0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h0) $display("FAIL bp_head%0d: got %0b %h want 1 0", k, instr_valid, instr_pc);
      else passed++;
      if (k >= 1) begin
        checks++;
        if (imem_pc !== 32'h8) $display("FAIL bp_imem_pc%0d: got %h want 8", k, imem_pc);
        else passed++;
      end
      @(negedge clk);
    end
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      e = exp_q.pop_front();
      checks++;
      if (instr_valid !== 1'b1 || {instr_pc, instr} !== e) $display("FAIL bp_burst%0d: got %0b %h want 1 %h", k, instr_valid, {instr_pc, instr}, e);
      else passed++;
      @(negedge clk);
    end
    run_stream(1'b1, 60, "bp_rest");
  endtask

  task automatic test_redirect();
    do_reset();
    load_short_rom();
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); instr_ready = 1'b1;
    @(negedge clk); instr_ready = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h4) $display("FAIL redir_pre: got %0b %h want 1 4", instr_valid, instr_pc);
    else passed++;
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    @(negedge clk); redirect_valid = 1'b0; #1;
    checks++;
    if (instr_valid !== 1'b0 || busy !== 1'b1) $display("FAIL redir_flush: got valid %0b busy %0b want 0 1", instr_valid, busy);
    else passed++;
    @(negedge clk); #1;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h10) $display("FAIL redir_target: got %0b %h want 1 10", instr_valid, instr_pc);
    else passed++;
    model_program(32'h10);
    run_stream(1'b1, 40, "redir");
  endtask

  task automatic test_misaligned_redirect();
    do_reset();
    load_short_rom();
    instr_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    @(negedge clk); redirect_valid = 1'b0; #1;
    checks++;
    if ({fault, halted, instr_valid, busy} !== 4'b1100) $display("FAIL misalign_flags: got %b want 1100", {fault, halted, instr_valid, busy});
    else passed++;
    model_program(32'h0);
    start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    checks++;
    if (fault !== 1'b0 || busy !== 1'b1) $display("FAIL misalign_restart: got fault %0b busy %0b want 0 1", fault, busy);
    else passed++;
    run_stream(1'b1, 40, "misalign_refetch");
  endtask

  task automatic test_range_limit();
    int n;
    do_reset();
    for (int i = 0; i < 8; i++) rom20[i] = 32'hA5A5_0000 + 32'(i + 1);
    instr_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (s_instr_valid !== 1'b1 || s_instr_pc !== 32'(4 * k) || s_instr !== rom20[k])
        $display("FAIL range_seq%0d: got %0b %h %h want 1 %h %h", k, s_instr_valid, s_instr_pc, s_instr, 32'(4 * k), rom20[k]);
      else passed++;
      @(negedge clk);
    end
    n = 0; #1;
    while (!s_halted && n < 10) begin @(negedge clk); #1; n++; end
    checks++;
    if ({s_halted, s_fault, s_instr_valid} !== 3'b110) $display("FAIL range_end: got %b want 110", {s_halted, s_fault, s_instr_valid});
    else passed++;
    checks++;
    if (s_imem_pc !== 32'd20) $display("FAIL range_pc: got %h want 14", s_imem_pc);
    else passed++;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    load_short_rom();
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (instr_valid !== 1'b1 || imem_pc !== 32'h8) $display("FAIL midreset_pre: got %0b %h want 1 8", instr_valid, imem_pc);
    else passed++;
    reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({instr_valid, busy, halted, fault} !== 4'b0 || dbg_state !== 2'd0 || imem_pc !== 32'h0)
      $display("FAIL midreset_post: got %b st %0d pc %h want 0000 0 0", {instr_valid, busy, halted, fault}, dbg_state, imem_pc);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_random_programs();
    int end_idx;
    do_reset();
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 32; i++) rom[i] = $urandom() | 32'h1;
      end_idx = $urandom_range(0, 27);
      if (end_idx < 25) rom[end_idx] = 32'h0;
      model_program(32'h0);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      run_stream(1'b1, 400, "rand");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_stream();
    test_backpressure();
    test_redirect();
    test_misaligned_redirect();
    test_range_limit();
    test_reset_midstream();
    test_random_programs();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
